// File: rtl/udp_hdmi_pkg.sv
// Shared definitions for the UDP/DRAM bridge (send and receive sides).
// Includes the packet layout, control-word field widths and the state encoding used for debug.
package udp_hdmi_pkg;

    localparam int HDR_WORDS = 4;              // UDP header words ahead of the address word
    localparam int ADDR_WORD = 4;              // packet index of the address word
    localparam int LEN_W     = 8;              // payload word count width
    localparam int ADDR_W    = 32;             // DRAM byte address width
    localparam int CTRL_W    = LEN_W + ADDR_W; // {len, addr} DRAM command

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FILL,
        ST_REQ,
        ST_HDR,
        ST_ADDR,
        ST_PAY,
        ST_DONE
    } udp_state_e;

    // Byte length carried in hdr[3]: the address word plus N payload words.
    function automatic logic [31:0] byte_len(input logic [LEN_W-1:0] n);
        return (32'(n) + 32'd1) << 2;
    endfunction

endpackage

// File: rtl/udp_send_buf.sv
// Simple dual-port payload buffer: one write port and one registered read port.
// Read data appears one cycle after the address is presented.
module udp_send_buf #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array has no reset; a reset would stop the tools from mapping it to block RAM,
    // and the FSM never reads a location that has not been written in the current transfer.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_hdmi_send.sv
// Transmit side of the UDP/DRAM bridge: reads N words from DRAM into a buffer,
// then emits one packet (4 header words, 1 address word, N payload words).
module udp_hdmi_send
    import udp_hdmi_pkg::*;
#(
    parameter int          BUF_AW   = 8,
    parameter logic [15:0] SRC_PORT = 16'd16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [31:0]       dst_ip,
    input  logic [15:0]       dst_port,
    output logic              busy,
    output logic              done,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_we,
    input  logic [31:0]       rd_data,
    input  logic              rd_valid,
    output logic              w_req,
    input  logic              w_ack,
    output logic              w_enable,
    output logic [31:0]       w_data
);

    localparam logic [1:0] HDR_LAST = 2'(ADDR_WORD - 1);

    udp_state_e                     state, state_nxt;
    logic [ADDR_W-1:0]              addr_r;
    logic [LEN_W-1:0]               len_r;
    logic [31:0]                    ip_r;
    logic [15:0]                    port_r;
    logic [LEN_W-1:0]               wr_cnt, rd_cnt, pay_cnt;
    logic [$clog2(HDR_WORDS)-1:0]   hdr_idx;
    logic [LEN_W-1:0]               last_idx;
    logic [31:0]                    buf_q;
    logic                           accept;
    logic                           buf_we;

    assign accept   = (state == ST_IDLE) && start && (start_len != '0);
    assign last_idx = len_r - LEN_W'(1);
    assign buf_we   = (state == ST_FILL) && rd_valid;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign ctrl_we  = (state == ST_CMD);
    assign w_req    = (state == ST_REQ);
    assign ctrl_out = {len_r, addr_r};

    udp_send_buf #(.AW(BUF_AW), .DW(32)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (BUF_AW'(wr_cnt)),
        .wdata (rd_data),
        .raddr (BUF_AW'(rd_cnt)),
        .rdata (buf_q)
    );

    // NOTE: state_nxt is assigned before the case so that every path drives it; no latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_CMD;
            ST_CMD:  state_nxt = ST_FILL;
            ST_FILL: if (rd_valid && wr_cnt == last_idx) state_nxt = ST_REQ;
            ST_REQ:  if (w_ack) state_nxt = ST_HDR;
            ST_HDR:  if (hdr_idx == HDR_LAST) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = ST_PAY;
            ST_PAY:  if (pay_cnt == last_idx) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // w_data is loaded one cycle ahead of the word it shows; rd_cnt runs two entries ahead
    // of the word on the output so the synchronous buffer read never inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_r   <= '0;
            len_r    <= '0;
            ip_r     <= '0;
            port_r   <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            pay_cnt  <= '0;
            hdr_idx  <= '0;
            w_enable <= 1'b0;
            w_data   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (accept) begin
                    addr_r  <= start_addr & ~32'h3;
                    len_r   <= start_len;
                    ip_r    <= dst_ip;
                    port_r  <= dst_port;
                    wr_cnt  <= '0;
                    rd_cnt  <= '0;
                    pay_cnt <= '0;
                end
                ST_FILL: if (rd_valid) wr_cnt <= wr_cnt + LEN_W'(1);
                ST_REQ: if (w_ack) begin
                    w_enable <= 1'b1;
                    w_data   <= ip_r;
                    hdr_idx  <= '0;
                end
                ST_HDR: begin
                    hdr_idx <= hdr_idx + 2'd1;
                    case (hdr_idx)
                        2'd0:    w_data <= {port_r, SRC_PORT};
                        2'd1:    w_data <= 32'h0;
                        2'd2:    w_data <= byte_len(len_r);
                        default: begin
                            w_data <= addr_r >> 2;
                            rd_cnt <= rd_cnt + LEN_W'(1);
                        end
                    endcase
                end
                ST_ADDR: begin
                    w_data <= buf_q;
                    rd_cnt <= rd_cnt + LEN_W'(1);
                end
                ST_PAY: begin
                    if (pay_cnt == last_idx) begin
                        w_enable <= 1'b0;
                        w_data   <= '0;
                    end else begin
                        w_data  <= buf_q;
                        pay_cnt <= pay_cnt + LEN_W'(1);
                        rd_cnt  <= rd_cnt + LEN_W'(1);
                    end
                end
                ST_DONE: begin
                    wr_cnt  <= '0;
                    rd_cnt  <= '0;
                    pay_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
